// File: rtl/fixed_clock_reset_sequencer.sv
// fixed_clock_reset_sequencer
//
// Purpose: takes one clock and one synchronous active-high reset and produces
// N_OUT clock/reset pairs. The clock outputs are plain copies of the input
// clock. The reset outputs are released one after another: channel i leaves
// reset HOLD_CYCLES + i*STAGGER_CYCLES edges after the input reset is
// deasserted. A channel that has been released can be put back into reset by
// software. It stays in reset while its request is high, and for HOLD_CYCLES
// edges after the request drops. A one-cycle ack marks the moment it comes
// back out of reset.
//
// Ports:
//   auto_in_clock   in   1      sole clock (rising edge)
//   auto_in_reset   in   1      synchronous active-high reset
//   auto_out_clock  out  N_OUT  copies of auto_in_clock, no logic in the path
//   auto_out_reset  out  N_OUT  registered per-channel reset, active-high
//   sw_reset_req    in   N_OUT  level-sensitive software reset request
//   sw_reset_ack    out  N_OUT  one-cycle pulse when a software reset finishes
//   all_released    out  1      registered, high when every channel is out of reset
//   seq_state       out  2      0=RESET 1=HOLD 2=RELEASE 3=RUN
module fixed_clock_reset_sequencer #(
  parameter int N_OUT          = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic             auto_in_clock,
  input  logic             auto_in_reset,
  output logic [N_OUT-1:0] auto_out_clock,
  output logic [N_OUT-1:0] auto_out_reset,
  input  logic [N_OUT-1:0] sw_reset_req,
  output logic [N_OUT-1:0] sw_reset_ack,
  output logic             all_released,
  output logic [1:0]       seq_state
);

  // Edge on which the last channel is released; the sequence counter never
  // needs to count beyond this value.
  localparam int LAST_EDGE = HOLD_CYCLES + (N_OUT - 1) * STAGGER_CYCLES;
  localparam int CW        = $clog2(LAST_EDGE + 1);
  localparam int SW        = $clog2(HOLD_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_EDGE);
  localparam logic [CW-1:0] CNT_HOLD = CW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [N_OUT-1:0] rst_next_vec;
  logic             all_released_reg;

  // The clock outputs are straight wires.
  assign auto_out_clock = {N_OUT{auto_in_clock}};

  // State register, sequence counter and all_released flag.
  always_ff @(posedge auto_in_clock) begin
    if (auto_in_reset) begin
      state_reg        <= ST_RESET;
      cnt_reg          <= '0;
      all_released_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      // all_released is computed from next-cycle reset values, so it rises
      // on the same edge as the final channel release.
      all_released_reg <= (rst_next_vec == '0);
    end
  end

  // Next-state logic. While the sequence runs, cnt_reg holds the number of
  // the edge that is about to happen. Edge 0 loads it with 1. The counter
  // stops at LAST_EDGE and does not wrap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_RESET: begin
        state_next = ST_HOLD;
        cnt_next   = CW'(1);
      end
      ST_HOLD: begin
        cnt_next = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + CW'(1);
        if (cnt_reg == CNT_HOLD) begin
          // With no stagger, or a single channel, the first release is also
          // the last, so RELEASE is skipped.
          state_next = (CNT_HOLD == CNT_LAST) ? ST_RUN : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        cnt_next = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + CW'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    seq_state    = state_reg;
    all_released = all_released_reg;
  end

  // Per-channel reset logic.
  genvar gi;
  for (gi = 0; gi < N_OUT; gi = gi + 1) begin : g_ch
    localparam logic [CW-1:0] THR = CW'(HOLD_CYCLES + gi * STAGGER_CYCLES);

    logic          released_reg, released_next;
    logic          rst_reg, rst_next;
    logic          ack_reg, ack_next;
    logic [SW-1:0] swcnt_reg, swcnt_next;

    // swcnt_reg is non-zero only while a software reset is counting down.
    always_comb begin
      released_next = released_reg;
      rst_next      = rst_reg;
      ack_next      = 1'b0;
      swcnt_next    = swcnt_reg;
      if (!released_reg) begin
        // Software requests are ignored until the initial release is done.
        if ((state_reg != ST_RESET) && (cnt_reg >= THR)) begin
          released_next = 1'b1;
          rst_next      = 1'b0;
        end
      end else if (sw_reset_req[gi]) begin
        rst_next   = 1'b1;
        swcnt_next = SW'(HOLD_CYCLES);
      end else if (swcnt_reg != '0) begin
        swcnt_next = swcnt_reg - SW'(1);
        if (swcnt_reg == SW'(1)) begin
          rst_next = 1'b0;
          ack_next = 1'b1;
        end
      end
    end

    always_ff @(posedge auto_in_clock) begin
      if (auto_in_reset) begin
        released_reg <= 1'b0;
        rst_reg      <= 1'b1;
        ack_reg      <= 1'b0;
        swcnt_reg    <= '0;
      end else begin
        released_reg <= released_next;
        rst_reg      <= rst_next;
        ack_reg      <= ack_next;
        swcnt_reg    <= swcnt_next;
      end
    end

    assign rst_next_vec[gi]   = rst_next;
    assign auto_out_reset[gi] = rst_reg;
    assign sw_reset_ack[gi]   = ack_reg;
  end

endmodule

// File: tb/tb_fixed_clock_reset_sequencer.sv
// Testbench for fixed_clock_reset_sequencer.
//
// Two instances are built. Instance A uses the default parameters
// (N_OUT=4, HOLD=16, STAGGER=4). Instance B uses STAGGER=0.
// A behavioural model, written in terms of edge numbers, predicts every
// output after every edge. A negedge process compares both instances against
// it. The directed scenarios also pin specific edges to literal values, and
// a randomized phase follows them.
module tb_fixed_clock_reset_sequencer;

  localparam int H = 16;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] clk_o_a, rst_o_a, ack_o_a;
  logic [3:0] clk_o_b, rst_o_b, ack_o_b;
  logic       all_a, all_b;
  logic [1:0] st_a, st_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit ack1_seen = 0;

  fixed_clock_reset_sequencer #(.N_OUT(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(4)) dut_a (
    .auto_in_clock (clk),
    .auto_in_reset (rst_a),
    .auto_out_clock(clk_o_a),
    .auto_out_reset(rst_o_a),
    .sw_reset_req  (req_a),
    .sw_reset_ack  (ack_o_a),
    .all_released  (all_a),
    .seq_state     (st_a)
  );

  fixed_clock_reset_sequencer #(.N_OUT(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(0)) dut_b (
    .auto_in_clock (clk),
    .auto_in_reset (rst_b),
    .auto_out_clock(clk_o_b),
    .auto_out_reset(rst_o_b),
    .sw_reset_req  (req_b),
    .sw_reset_ack  (ack_o_b),
    .all_released  (all_b),
    .seq_state     (st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_e is the edge number since reset release. It is -1 while the reset
  // state holds. m_tgt is the edge at which a pending software reset ends,
  // or -1 when none is pending.
  bit         m_valid [2];
  int         m_e     [2];
  int         m_tgt   [2][4];
  logic [3:0] x_rst   [2];
  logic [3:0] x_ack   [2];
  logic       x_all   [2];
  logic [1:0] x_st    [2];

  task automatic model_edge(input int d, input logic rst, input logic [3:0] req);
    int s;
    int ie;
    s = (d == 0) ? 4 : 0;
    if (rst) begin
      m_valid[d] = 1'b1;
      m_e[d]     = -1;
      x_rst[d]   = 4'hF;
      x_ack[d]   = 4'h0;
      x_all[d]   = 1'b0;
      x_st[d]    = 2'd0;
      for (int i = 0; i < 4; i++) m_tgt[d][i] = -1;
    end else if (m_valid[d]) begin
      m_e[d]   = m_e[d] + 1;
      x_ack[d] = 4'h0;
      for (int i = 0; i < 4; i++) begin
        ie = H + i * s;
        if (m_e[d] < ie) begin
          x_rst[d][i] = 1'b1;
        end else if (m_e[d] == ie) begin
          x_rst[d][i] = 1'b0;
        end else if (req[i]) begin
          m_tgt[d][i] = m_e[d] + H;
          x_rst[d][i] = 1'b1;
        end else if (m_tgt[d][i] == m_e[d]) begin
          m_tgt[d][i] = -1;
          x_rst[d][i] = 1'b0;
          x_ack[d][i] = 1'b1;
        end else begin
          x_rst[d][i] = (m_tgt[d][i] >= 0);
        end
      end
      x_all[d] = (x_rst[d] == 4'h0);
      if (m_e[d] >= H + 3 * s) x_st[d] = 2'd3;
      else if (m_e[d] >= H)    x_st[d] = 2'd2;
      else                     x_st[d] = 2'd1;
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, rst_a, req_a);
    model_edge(1, rst_b, req_b);
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (m_valid[0]) begin
      check("a_out_reset", rst_o_a, x_rst[0]);
      check("a_ack", ack_o_a, x_ack[0]);
      check("a_all_released", all_a, x_all[0]);
      check("a_seq_state", st_a, x_st[0]);
      check("a_out_clock", clk_o_a, 4'h0);
    end
    if (m_valid[1]) begin
      check("b_out_reset", rst_o_b, x_rst[1]);
      check("b_ack", ack_o_b, x_ack[1]);
      check("b_all_released", all_b, x_all[1]);
      check("b_seq_state", st_b, x_st[1]);
      check("b_out_clock", clk_o_b, 4'h0);
    end
    if (ack_o_a[1]) ack1_seen = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reset for one edge, then release and check literal values on the way up
  // to edge 30.
  task automatic power_on(input bit both);
    rst_a = 1'b1;
    if (both) rst_b = 1'b1;
    step();
    check("por_rst_a", rst_o_a, 4'hF);
    check("por_state_a", st_a, 2'd0);
    check("por_all_a", all_a, 1'b0);
    check("por_clk_a_high", clk_o_a, 4'hF);
    rst_a = 1'b0;
    if (both) rst_b = 1'b0;
    step();
    check("edge0_state_a", st_a, 2'd1);
    for (int e = 1; e <= 30; e++) begin
      step();
      case (e)
        15: begin
          check("e15_rst_a", rst_o_a, 4'hF);
          if (both) begin
            check("e15_rst_b", rst_o_b, 4'hF);
            check("e15_state_b", st_b, 2'd1);
          end
        end
        16: begin
          check("e16_rst_a", rst_o_a, 4'hE);
          check("e16_state_a", st_a, 2'd2);
          if (both) begin
            check("e16_rst_b", rst_o_b, 4'h0);
            check("e16_state_b", st_b, 2'd3);
            check("e16_all_b", all_b, 1'b1);
          end
        end
        20: check("e20_rst_a", rst_o_a, 4'hC);
        24: check("e24_rst_a", rst_o_a, 4'h8);
        27: begin
          check("e27_rst_a", rst_o_a, 4'h8);
          check("e27_state_a", st_a, 2'd2);
          check("e27_all_a", all_a, 1'b0);
        end
        28: begin
          check("e28_rst_a", rst_o_a, 4'h0);
          check("e28_all_a", all_a, 1'b1);
          check("e28_state_a", st_a, 2'd3);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    req_a = 4'h0;
    req_b = 4'h0;
    repeat (3) step();

    // Power-on release on both instances; current edge is 30 afterwards.
    power_on(1'b1);

    // Software reset pulse on channel 2 at edge 100.
    repeat (69) step();
    req_a = 4'b0100;
    step();
    req_a = 4'h0;
    check("sw100_rst", rst_o_a, 4'b0100);
    check("sw100_all", all_a, 1'b0);
    repeat (15) step();
    check("sw115_rst", rst_o_a, 4'b0100);
    check("sw115_ack", ack_o_a, 4'h0);
    step();
    check("sw116_rst", rst_o_a, 4'h0);
    check("sw116_ack", ack_o_a, 4'b0100);
    check("sw116_all", all_a, 1'b1);
    step();
    check("sw117_ack", ack_o_a, 4'h0);

    // Held request on ch0 over edges 200..209, single-edge request on ch3 at 200.
    repeat (82) step();
    req_a = 4'b1001;
    step();
    req_a = 4'b0001;
    repeat (9) step();
    req_a = 4'h0;
    check("held209_rst", rst_o_a, 4'b1001);
    repeat (7) step();
    check("held216_rst", rst_o_a, 4'b0001);
    check("held216_ack", ack_o_a, 4'b1000);
    repeat (8) step();
    check("held224_rst", rst_o_a, 4'b0001);
    check("held224_ack", ack_o_a, 4'h0);
    step();
    check("held225_rst", rst_o_a, 4'h0);
    check("held225_ack", ack_o_a, 4'b0001);
    check("held225_all", all_a, 1'b1);

    // Mid-sequence reset at edge 22.
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    step();
    repeat (21) step();
    check("mid21_rst", rst_o_a, 4'b1100);
    rst_a = 1'b1;
    step();
    check("mid22_rst", rst_o_a, 4'hF);
    check("mid22_state", st_a, 2'd0);
    check("mid22_all", all_a, 1'b0);
    power_on(1'b0);

    // Reset while channel 1 is in software reset.
    repeat (9) step();
    req_a = 4'b0010;
    step();
    req_a = 4'h0;
    repeat (5) step();
    check("swr45_rst", rst_o_a, 4'b0010);
    rst_a = 1'b1;
    step();
    check("swr_reset_rst", rst_o_a, 4'hF);
    check("swr_reset_ack", ack_o_a, 4'h0);
    rst_a = 1'b0;
    ack1_seen = 1'b0;
    repeat (40) step();
    check("swr_no_ack1", ack1_seen, 1'b0);
    check("swr_rerun_rst", rst_o_a, 4'h0);
    check("swr_rerun_state", st_a, 2'd3);

    // Randomized phase against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_a = ($urandom_range(0, 499) == 0);
      rst_b = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 4; i++) begin
        req_a[i] = req_a[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
        req_b[i] = req_b[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_clock_reset_sequencer.md
FIXED_CLOCK_RESET_SEQUENCER -- requirements
Module: fixed_clock_reset_sequencer

Interface
REQ-001 Parameters SHALL be: N_OUT, default 4, output channel count (legal 1..8); HOLD_CYCLES, default 16, reset hold length (legal 1..255); STAGGER_CYCLES, default 4, gap between channel releases (legal 0..255).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- auto_in_clock  in  1  sole clock; every register is clocked on its rising edge.
- auto_in_reset  in  1  reset, synchronous and active-high.
- auto_out_clock  out  N_OUT  each bit a direct copy of auto_in_clock, with no gating and no logic.
- auto_out_reset  out  N_OUT  per-channel sequenced reset, registered, active-high.
- sw_reset_req  in  N_OUT  per-channel software reset request, level-sensitive.
- sw_reset_ack  out  N_OUT  one-cycle pulse when a software reset of that channel completes.
- all_released  out  1  high when every auto_out_reset bit is 0.
- seq_state  out  2  sequencer state: 0=RESET, 1=HOLD, 2=RELEASE, 3=RUN.

Function
REQ-003 The block SHALL have exactly one clock domain; the reset SHALL be synchronous to auto_in_clock and active-high; all outputs except auto_out_clock SHALL be registered.
REQ-004 Edge numbering: edge 0 SHALL be the first rising edge that samples auto_in_reset=0 after it was 1.
REQ-005 The sequencer FSM SHALL make these transitions:
- RESET to HOLD at edge 0.
- HOLD to RELEASE when the first channel is released.
- RELEASE to RUN at the edge on which channel N_OUT-1 is released.
- Any state to RESET on any edge that samples auto_in_reset=1.
REQ-006 auto_out_reset[i] SHALL go to 0 at edge HOLD_CYCLES + i*STAGGER_CYCLES.
REQ-007 When STAGGER_CYCLES=0, all channels SHALL release at the same edge HOLD_CYCLES, and the FSM SHALL go directly from HOLD to RUN at that edge.
REQ-008 The release counter SHALL be an unsigned counter of width clog2(HOLD_CYCLES + (N_OUT-1)*STAGGER_CYCLES + 1); it SHALL saturate in RUN and SHALL NOT wrap.
REQ-009 all_released SHALL be 1 exactly when all auto_out_reset bits are 0; it SHALL assert on the same edge as the last channel release.
REQ-010 Software reset, for channel i already released: an edge that samples sw_reset_req[i]=1 SHALL set auto_out_reset[i]=1 at that edge and SHALL load channel counter i with HOLD_CYCLES.
REQ-011 While sw_reset_req[i] stays 1, channel counter i SHALL reload on every edge.
REQ-012 Once sw_reset_req[i] is 0, channel counter i SHALL decrement on each edge; auto_out_reset[i] SHALL return to 0 at edge e+HOLD_CYCLES, where e is the last edge that sampled the request high.
REQ-013 sw_reset_ack[i] SHALL pulse high for exactly one cycle, on the same edge that auto_out_reset[i] returns to 0 after a software reset.
REQ-014 sw_reset_req[i] SHALL be ignored while channel i has not yet completed its initial release (states RESET and HOLD, and in RELEASE before that channel's release edge).
REQ-015 Software resets on different channels SHALL be independent.
- Simultaneous requests each time out on their own counters.
- A software reset SHALL NOT affect the FSM state or any other channel.
REQ-016 auto_in_reset=1 during any operation, including during a software reset, SHALL take priority at that edge. The block SHALL:
- abort pending software resets with no ack;
- return all outputs to their reset values;
- restart the sequence at the next edge 0.

Reset
REQ-017 When auto_in_reset is sampled high, the next edge SHALL give: auto_out_reset all ones, sw_reset_ack all zeros, all_released=0, seq_state=0, all counters cleared.
REQ-018 auto_out_clock SHALL follow auto_in_clock during reset and at all other times.

Verification
REQ-019 The bench SHALL run these directed scenarios with N_OUT=4, HOLD_CYCLES=16 and STAGGER_CYCLES=4 unless stated otherwise:
- Power-on release: hold reset, then deassert -> channels 0..3 release at edges 16, 20, 24, 28; all_released rises at edge 28; seq_state goes 1 then 2 then 3.
- No stagger: STAGGER_CYCLES=0 -> all four channels release at edge 16; seq_state goes from 1 to 3 at edge 16.
- Software reset pulse: sw_reset_req[2]=1 sampled only at edge 100 -> auto_out_reset[2]=1 from edge 100 to edge 116; sw_reset_ack[2] high only for the cycle after edge 116; all_released low over the same window; other channels stay 0.
- Held request and simultaneous channels: sw_reset_req[0] held high over edges 100..109, and sw_reset_req[3] sampled high only at edge 100 -> channel 3 releases and acks at edge 116; channel 0 releases and acks at edge 125.
- Mid-sequence reset: auto_in_reset=1 sampled at edge 22 (channels 0 and 1 released) -> next edge gives all ones and seq_state=0; the re-run after deassert releases channels at edges 16, 20, 24, 28 again.
- Reset during software reset: auto_in_reset=1 while channel 1 is in software reset -> no ack is ever produced for channel 1; the full sequence restarts.
